mode_ctrl: RTL and testbench
============================

MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 Parameter DEB_CNT, default 2_000_000; debounce stability window in sys_clk cycles (20 ms at 100 MHz).
REQ-002 Parameter NUM_MAX, default 9; highest track index selectable in play modes (range 1..15).
REQ-003 Parameter REPEAT_CNT, default 25_000_000; auto-repeat period in cycles (used only under REQ-024).
REQ-004 sys_clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 sys_rst  in  1  synchronous, active-high reset.
REQ-006 btn_up, btn_down, btn_ok, btn_back  in  1 each  raw asynchronous push-buttons, active-high.
REQ-007 done  in  1  one-cycle pulse from the playback engine: current learn/auto run has finished.
REQ-008 status  out  7  registered one-hot screen code; feeds the VGA picture generator's status input.
REQ-009 num  out  4  registered selection index; feeds the VGA picture generator's num input.
REQ-010 key_valid  out  1  registered one-cycle pulse for each accepted button event.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer before any other use.
REQ-012 A debounced level SHALL change only after the synchronized input holds the new value for DEB_CNT consecutive cycles; any mismatch restarts that button's counter at 0.
REQ-013 A press event SHALL be a 0->1 transition of a debounced level; releases generate no event.
REQ-014 Latency: with a clean press, key_valid, status and num SHALL update on the same edge, exactly DEB_CNT+3 cycles after the first edge at which the raw input is sampled high.
REQ-015 Encodings: IDLE=0000001, MENU=0000010, FREE=0000100, LEARN=0001000, AUTO=0010000, RESULT=0100000, PAUSE=1000000; status SHALL never carry any other value.
REQ-016 Event priority within one cycle: back > done > ok > up > down; only the highest-priority event is acted on and the rest are discarded; key_valid pulses once if any button event exists, even when done wins.
REQ-017 IDLE: ok -> MENU, num=0; all other events ignored.
REQ-018 MENU: up increments num 0->1->2->0; down decrements 0->2; ok -> FREE/LEARN/AUTO for num=0/1/2, num=0; back -> IDLE, num=0.
REQ-019 FREE/LEARN/AUTO: up increments num, wrapping NUM_MAX->0; down decrements, wrapping 0->NUM_MAX; back -> MENU with num = mode index (FREE 0, LEARN 1, AUTO 2).
REQ-020 done SHALL move LEARN or AUTO to RESULT with num held; done SHALL be ignored in every other state, including PAUSE.
REQ-021 AUTO: ok -> PAUSE. PAUSE: ok -> AUTO, back -> MENU with num=2; up/down ignored; num held.
REQ-022 RESULT: ok or back -> MENU with num = index of the mode that produced the result; up/down ignored.

Reset
REQ-023 When sys_rst is high at an edge: status=0000001, num=0, key_valid=0, synchronizers, debounced levels and all counters = 0; a button held through reset SHALL produce no event until it is released and pressed again.

Configuration
REQ-024 Macro MODE_CTRL_AUTOREPEAT_EN: when defined, if btn_up or btn_down stays debounced-high, an additional press event SHALL be generated every REPEAT_CNT cycles after the initial event while it remains high; ok and back never repeat. When undefined, each press yields exactly one event and no repeat counter is built.

Verification
REQ-025 DEB_CNT=4: raw btn_ok high from cycle 0 in IDLE -> key_valid pulse and status 0000001->0000010 at edge 7; a 3-cycle glitch -> no event.
REQ-026 MENU with num=2, press up -> num=0; press ok -> status=0000100 (FREE), num=0; press down -> num=NUM_MAX (9).
REQ-027 LEARN: done pulse in the same cycle as an accepted btn_up -> status=0100000, num unchanged, key_valid=1; then btn_back -> MENU, num=1.
REQ-028 AUTO -> ok -> PAUSE (1000000); done pulse -> no change; ok -> AUTO (0010000); back -> MENU, num=2.
REQ-029 Assert sys_rst mid-debounce of btn_up while in FREE with num=5 -> next edge status=0000001, num=0, no key_valid; btn_up held afterwards -> no event until release and re-press.
REQ-030 With MODE_CTRL_AUTOREPEAT_EN, REPEAT_CNT=10, btn_up held in FREE from num=0 -> num 1,2,3 at 10-cycle spacing after the first event; without the macro -> num stays 1.

Source files
------------

// File: rtl/mode_ctrl_if.sv
// Button/done inputs and screen outputs exchanged between the panel front-end and mode_ctrl.
interface mode_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_ok;
    logic       btn_back;
    logic       done;
    logic [6:0] status;
    logic [3:0] num;
    logic       key_valid;

    modport master (
        output btn_up, btn_down, btn_ok, btn_back, done,
        input  status, num, key_valid
    );

    modport slave (
        input  btn_up, btn_down, btn_ok, btn_back, done,
        output status, num, key_valid
    );
endinterface

// File: rtl/mode_ctrl.sv
// Push-button mode controller: sync + debounce + press detect feeding the screen/selection FSM.
// Optional macro MODE_CTRL_AUTOREPEAT_EN adds auto-repeat on held up/down buttons.
module mode_ctrl #(
    parameter int DEB_CNT    = 2_000_000,
    parameter int NUM_MAX    = 9,
    parameter int REPEAT_CNT = 25_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    mode_ctrl_if.slave  bus
);
    localparam int              DW       = $clog2(DEB_CNT + 1);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CNT - 1);
    localparam logic [3:0]      NMAX     = 4'(NUM_MAX);

    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        MENU   = 7'b0000010,
        FREE   = 7'b0000100,
        LEARN  = 7'b0001000,
        AUTO   = 7'b0010000,
        RESULT = 7'b0100000,
        PAUSE  = 7'b1000000
    } state_t;

    // Button index order: 0 up, 1 down, 2 ok, 3 back.
    logic [3:0] raw;
    logic [3:0] press;
    logic [1:0] settle_q;

    assign raw = {bus.btn_back, bus.btn_ok, bus.btn_down, bus.btn_up};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic          sync1_q, sync2_q, deb_q, deb_prev_q, lock_q, press_q;
            logic [DW-1:0] cnt_q;
            logic          rise;

            // lock_q masks the first rise after reset so a button held through reset stays silent.
            assign rise       = deb_q & ~deb_prev_q & ~lock_q;
            assign press[gi]  = press_q;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    lock_q     <= 1'b1;
                    cnt_q      <= '0;
                end else begin
                    sync1_q    <= raw[gi];
                    sync2_q    <= sync1_q;
                    deb_prev_q <= deb_q;
                    if (sync2_q != deb_q) begin
                        if (cnt_q == DEB_LAST) begin
                            deb_q <= sync2_q;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                    if (lock_q && settle_q == 2'd2 && !sync2_q && !deb_q)
                        lock_q <= 1'b0;
                end
            end

`ifdef MODE_CTRL_AUTOREPEAT_EN
            if (gi < 2) begin : g_rep
                localparam int            RW       = $clog2(REPEAT_CNT + 1);
                localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
                logic [RW-1:0] rep_q;

                always_ff @(posedge sys_clk) begin
                    if (sys_rst) begin
                        press_q <= 1'b0;
                        rep_q   <= '0;
                    end else if (rise) begin
                        press_q <= 1'b1;
                        rep_q   <= '0;
                    end else if (deb_q && deb_prev_q && !lock_q) begin
                        press_q <= (rep_q == REP_LAST);
                        rep_q   <= (rep_q == REP_LAST) ? '0 : rep_q + 1'b1;
                    end else begin
                        press_q <= 1'b0;
                        rep_q   <= '0;
                    end
                end
            end else begin : g_norep
                always_ff @(posedge sys_clk) begin
                    if (sys_rst) press_q <= 1'b0;
                    else         press_q <= rise;
                end
            end
`else
            always_ff @(posedge sys_clk) begin
                if (sys_rst) press_q <= 1'b0;
                else         press_q <= rise;
            end
`endif
        end
    endgenerate

    state_t     state_q, state_d;
    logic [3:0] num_q, num_d;
    logic [1:0] src_q, src_d;
    logic       kv_q, kv_d;
    logic       ev_back, ev_done, ev_ok, ev_up, ev_down;
    logic [1:0] mode_idx;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        src_d    = src_q;
        kv_d     = |press;
        ev_back  = 1'b0;
        ev_done  = 1'b0;
        ev_ok    = 1'b0;
        ev_up    = 1'b0;
        ev_down  = 1'b0;
        mode_idx = (state_q == LEARN) ? 2'd1 : (state_q == AUTO) ? 2'd2 : 2'd0;

        // done only counts as an event where it has an effect.
        if (press[3])                                             ev_back = 1'b1;
        else if (bus.done && (state_q == LEARN || state_q == AUTO)) ev_done = 1'b1;
        else if (press[2])                                        ev_ok   = 1'b1;
        else if (press[0])                                        ev_up   = 1'b1;
        else if (press[1])                                        ev_down = 1'b1;

        case (state_q)
            IDLE: begin
                if (ev_ok) begin
                    state_d = MENU;
                    num_d   = 4'd0;
                end
            end
            MENU: begin
                if (ev_back) begin
                    state_d = IDLE;
                    num_d   = 4'd0;
                end else if (ev_ok) begin
                    state_d = (num_q == 4'd0) ? FREE : (num_q == 4'd1) ? LEARN : AUTO;
                    num_d   = 4'd0;
                end else if (ev_up) begin
                    num_d = (num_q >= 4'd2) ? 4'd0 : num_q + 4'd1;
                end else if (ev_down) begin
                    num_d = (num_q == 4'd0) ? 4'd2 : num_q - 4'd1;
                end
            end
            FREE, LEARN, AUTO: begin
                if (ev_back) begin
                    state_d = MENU;
                    num_d   = {2'b00, mode_idx};
                end else if (ev_done) begin
                    state_d = RESULT;
                    src_d   = mode_idx;
                end else if (ev_ok) begin
                    if (state_q == AUTO) state_d = PAUSE;
                end else if (ev_up) begin
                    num_d = (num_q >= NMAX) ? 4'd0 : num_q + 4'd1;
                end else if (ev_down) begin
                    num_d = (num_q == 4'd0) ? NMAX : num_q - 4'd1;
                end
            end
            PAUSE: begin
                if (ev_back) begin
                    state_d = MENU;
                    num_d   = 4'd2;
                end else if (ev_ok) begin
                    state_d = AUTO;
                end
            end
            RESULT: begin
                if (ev_back || ev_ok) begin
                    state_d = MENU;
                    num_d   = {2'b00, src_q};
                end
            end
            default: begin
                state_d = IDLE;
                num_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            num_q    <= 4'd0;
            src_q    <= 2'd0;
            kv_q     <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            src_q    <= src_d;
            kv_q     <= kv_d;
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
        end
    end

    assign bus.status    = state_q;
    assign bus.num       = num_q;
    assign bus.key_valid = kv_q;
endmodule

// File: tb/tb_mode_ctrl.sv
// Bench for mode_ctrl: event-timeline model + per-cycle compare, plus literal checkpoints.
module tb_mode_ctrl;
    localparam int DEB     = 4;
    localparam int NMAX    = 9;
    localparam int REP     = 10;
    localparam int SCHED_N = 8192;

    localparam logic [6:0] S_IDLE   = 7'b0000001;
    localparam logic [6:0] S_MENU   = 7'b0000010;
    localparam logic [6:0] S_FREE   = 7'b0000100;
    localparam logic [6:0] S_LEARN  = 7'b0001000;
    localparam logic [6:0] S_AUTO   = 7'b0010000;
    localparam logic [6:0] S_RESULT = 7'b0100000;
    localparam logic [6:0] S_PAUSE  = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw = 4'b0;
    logic       done_r = 1'b0;
    logic       chk_en = 1'b0;
    logic       last_kv = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    logic [3:0] sched [0:SCHED_N-1];
    logic [6:0] m_st = S_IDLE;
    logic [3:0] m_num = 4'd0;
    logic [1:0] m_src = 2'd0;
    logic       m_kv = 1'b0;

    mode_ctrl_if bif();
    assign bif.btn_up   = raw[0];
    assign bif.btn_down = raw[1];
    assign bif.btn_ok   = raw[2];
    assign bif.btn_back = raw[3];
    assign bif.done     = done_r;

    mode_ctrl #(.DEB_CNT(DEB), .NUM_MAX(NMAX), .REPEAT_CNT(REP)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    // Screen rules applied to one cycle's event set (bit 0 up, 1 down, 2 ok, 3 back).
    function automatic logic [12:0] step(input logic [6:0] st, input logic [3:0] n,
                                         input logic [1:0] src, input logic [3:0] ev, input logic dn);
        logic [6:0] s2;
        logic [3:0] n2;
        logic [1:0] r2;
        int mode, lim;
        s2 = st; n2 = n; r2 = src;
        mode = (st == S_FREE) ? 0 : (st == S_LEARN) ? 1 : 2;
        lim  = (st == S_MENU) ? 2 : NMAX;
        if (ev[3]) begin
            if (st == S_MENU) begin s2 = S_IDLE; n2 = 4'd0; end
            else if (st == S_FREE || st == S_LEARN || st == S_AUTO) begin s2 = S_MENU; n2 = 4'(mode); end
            else if (st == S_PAUSE) begin s2 = S_MENU; n2 = 4'd2; end
            else if (st == S_RESULT) begin s2 = S_MENU; n2 = {2'b00, src}; end
        end else if (dn && (st == S_LEARN || st == S_AUTO)) begin
            s2 = S_RESULT; r2 = 2'(mode);
        end else if (ev[2]) begin
            if (st == S_IDLE) begin s2 = S_MENU; n2 = 4'd0; end
            else if (st == S_MENU) begin s2 = (n == 0) ? S_FREE : (n == 1) ? S_LEARN : S_AUTO; n2 = 4'd0; end
            else if (st == S_AUTO) s2 = S_PAUSE;
            else if (st == S_PAUSE) s2 = S_AUTO;
            else if (st == S_RESULT) begin s2 = S_MENU; n2 = {2'b00, src}; end
        end else if ((ev[0] || ev[1]) &&
                     (st == S_MENU || st == S_FREE || st == S_LEARN || st == S_AUTO)) begin
            if (ev[0]) n2 = 4'((int'(n) + 1) % (lim + 1));
            else       n2 = 4'((int'(n) + lim) % (lim + 1));
        end
        return {s2, n2, r2};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_st <= S_IDLE; m_num <= 4'd0; m_src <= 2'd0; m_kv <= 1'b0;
        end else begin
            m_kv <= ((cyc < SCHED_N) ? sched[cyc] : 4'b0) != 4'b0;
            {m_st, m_num, m_src} <= step(m_st, m_num, m_src,
                                         (cyc < SCHED_N) ? sched[cyc] : 4'b0, done_r);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_status", 32'(bif.status), 32'(m_st));
            check("cyc_num", 32'(bif.num), 32'(m_num));
            check("cyc_key_valid", 32'(bif.key_valid), 32'(m_kv));
        end
    end

    // Called right after a negedge; the next posedge is edge number cyc.
    task automatic press(input int b, input int len, input bit with_done);
        int e0, evt, end_c;
        e0 = cyc; evt = -10; last_kv = 1'b0;
        if (len >= DEB) begin
            evt = e0 + DEB + 3;
            sched[evt] = sched[evt] | 4'(1 << b);
`ifdef MODE_CTRL_AUTOREPEAT_EN
            if (b < 2)
                for (int k = 1; k * REP <= len - 1; k++)
                    sched[evt + k * REP] = sched[evt + k * REP] | 4'(1 << b);
`endif
        end
        end_c = e0 + len + DEB + 6;
        while (cyc < end_c) begin
            raw[b] = (cyc < e0 + len);
            done_r = with_done && (cyc == evt);
            @(negedge clk);
            if (cyc == evt + 1) last_kv = bif.key_valid;
        end
        raw[b] = 1'b0;
        done_r = 1'b0;
        $display("press btn=%0d len=%0d done=%0d -> status=%b num=%0d kv_at_event=%0d",
                 b, len, with_done, bif.status, bif.num, last_kv);
    endtask

    task automatic pulse_done();
        done_r = 1'b1;
        @(negedge clk);
        done_r = 1'b0;
        repeat (3) @(negedge clk);
        $display("done pulse -> status=%b num=%0d", bif.status, bif.num);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e0;
        logic kv_seen;
        for (int i = 0; i < SCHED_N; i++) sched[i] = 4'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_status", 32'(bif.status), 32'(S_IDLE));
        check("rst_num", 32'(bif.num), 0);
        check("rst_kv", 32'(bif.key_valid), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clean ok press in IDLE: outputs change at the 7th edge after the first high sample.
        e0 = cyc;
        sched[e0 + DEB + 3] = 4'b0100;
        raw[2] = 1'b1;
        repeat (7) @(negedge clk);
        check("lat_before_status", 32'(bif.status), 32'(S_IDLE));
        check("lat_before_kv", 32'(bif.key_valid), 0);
        @(negedge clk);
        check("lat_status", 32'(bif.status), 32'(S_MENU));
        check("lat_kv", 32'(bif.key_valid), 1);
        raw[2] = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        $display("ok latency run -> status=%b num=%0d", bif.status, bif.num);

        press(0, 3, 0);        check("glitch_num", 32'(bif.num), 0);
        press(0, DEB + 2, 0);
        press(0, DEB + 2, 0);  check("menu_num2", 32'(bif.num), 2);
        press(0, DEB + 2, 0);  check("menu_wrap_up", 32'(bif.num), 0);
        press(2, DEB + 2, 0);  check("free_status", 32'(bif.status), 32'(S_FREE));
                               check("free_num", 32'(bif.num), 0);
        press(1, DEB + 2, 0);  check("free_wrap_down", 32'(bif.num), 9);
        press(0, DEB + 2, 0);  check("free_wrap_up", 32'(bif.num), 0);
        press(3, DEB + 2, 0);  check("free_back", 32'(bif.status), 32'(S_MENU));
        press(1, DEB + 2, 0);  check("menu_wrap_down", 32'(bif.num), 2);
        press(1, DEB + 2, 0);  check("menu_down", 32'(bif.num), 1);
        press(2, DEB + 2, 0);  check("learn_status", 32'(bif.status), 32'(S_LEARN));
        press(0, DEB + 2, 0);  check("learn_num", 32'(bif.num), 1);
        press(0, DEB + 2, 1);  check("done_wins_status", 32'(bif.status), 32'(S_RESULT));
                               check("done_wins_num", 32'(bif.num), 1);
                               check("done_wins_kv", 32'(last_kv), 1);
        press(0, DEB + 2, 0);  check("result_up_ignored", 32'(bif.num), 1);
        press(3, DEB + 2, 0);  check("result_back_num", 32'(bif.num), 1);
                               check("result_back_st", 32'(bif.status), 32'(S_MENU));
        press(0, DEB + 2, 0);
        press(2, DEB + 2, 0);  check("auto_status", 32'(bif.status), 32'(S_AUTO));
        press(2, DEB + 2, 0);  check("pause_status", 32'(bif.status), 32'(S_PAUSE));
        pulse_done();          check("pause_done_ign", 32'(bif.status), 32'(S_PAUSE));
        press(2, DEB + 2, 0);  check("resume_status", 32'(bif.status), 32'(S_AUTO));
        press(3, DEB + 2, 0);  check("auto_back_num", 32'(bif.num), 2);
        press(2, DEB + 2, 0);
        press(0, DEB + 2, 0);
        pulse_done();          check("auto_result", 32'(bif.status), 32'(S_RESULT));
        press(2, DEB + 2, 0);  check("auto_result_ok", 32'(bif.num), 2);
        press(3, DEB + 2, 0);  check("menu_back_idle", 32'(bif.status), 32'(S_IDLE));

        // Reset in the middle of an up debounce while in FREE with num=5.
        press(2, DEB + 2, 0);
        press(2, DEB + 2, 0);
        for (int i = 0; i < 5; i++) press(0, DEB + 2, 0);
        check("pre_rst_num", 32'(bif.num), 5);
        raw[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_status", 32'(bif.status), 32'(S_IDLE));
        check("midrst_num", 32'(bif.num), 0);
        check("midrst_kv", 32'(bif.key_valid), 0);
        kv_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            kv_seen = kv_seen | bif.key_valid;
        end
        check("held_no_event", 32'(kv_seen), 0);
        raw[0] = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        $display("held through reset -> status=%b num=%0d", bif.status, bif.num);
        press(0, DEB + 2, 0);  check("repress_kv", 32'(last_kv), 1);
                               check("repress_idle", 32'(bif.status), 32'(S_IDLE));

        // Long up hold in FREE from num=0.
        press(2, DEB + 2, 0);
        press(2, DEB + 2, 0);
        press(0, 25, 0);
`ifdef MODE_CTRL_AUTOREPEAT_EN
        check("hold_num", 32'(bif.num), 3);
`else
        check("hold_num", 32'(bif.num), 1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
